// File: rtl/btn_event_encoder.sv
// btn_event_encoder: debounces three raw buttons and queues one 2-bit code per accepted press.
// Ports: clock/reset (sync, active-high); btn[2:0] raw buttons; ack pops the head event;
//        valid/code present the oldest event; multi_err pulses on a debounced multi-button press;
//        overflow pulses when an event is dropped on a full buffer.
// Macro BTN_EVENT_ENCODER_FIFO_EN selects a 4-entry FIFO; otherwise a single holding register.
module btn_event_encoder #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [2:0] btn,
   input  logic       ack,
   output logic       valid,
   output logic [1:0] code,
   output logic       multi_err,
   output logic       overflow
);
   typedef enum logic [1:0] {IDLE, DEBOUNCE, EMIT, RELEASE} state_t;
   localparam logic [7:0] LAST = 8'(DEBOUNCE_CYCLES - 1);
   state_t state, state_n;
   logic [2:0] s1, sbtn, pat, pat_n;
   logic [7:0] cnt, cnt_n;
   logic merr_n, onehot, push, pop, full;
   logic [1:0] pcode;
   assign onehot = pat inside {3'b001, 3'b010, 3'b100};
   assign pcode = {pat[2], pat[1]};
   assign push = state == EMIT;
   assign pop = ack && valid;
   always_ff @(posedge clock) begin
      if (reset) begin
         s1 <= '0;
         sbtn <= '0;
         state <= IDLE;
         cnt <= '0;
         pat <= '0;
         multi_err <= 1'b0;
         overflow <= 1'b0;
      end else begin
         s1 <= btn;
         sbtn <= s1;
         state <= state_n;
         cnt <= cnt_n;
         pat <= pat_n;
         multi_err <= merr_n;
         overflow <= push && full && !pop;
      end
   end
   always_comb begin
      state_n = state;
      cnt_n = cnt;
      pat_n = pat;
      merr_n = 1'b0;
      case (state)
         IDLE:
            if (sbtn != 3'b000) begin
               pat_n = sbtn;
               cnt_n = '0;
               state_n = DEBOUNCE;
            end
         DEBOUNCE:
            if (sbtn != pat) state_n = IDLE;
            else if (cnt == LAST) begin
               state_n = onehot ? EMIT : RELEASE;
               merr_n = !onehot;
               cnt_n = '0;
            end else cnt_n = cnt + 8'd1;
         EMIT: begin
            state_n = RELEASE;
            cnt_n = '0;
         end
         default:
            if (sbtn != 3'b000) cnt_n = '0;
            else if (cnt == LAST) begin
               state_n = IDLE;
               cnt_n = '0;
            end else cnt_n = cnt + 8'd1;
      endcase
   end
`ifdef BTN_EVENT_ENCODER_FIFO_EN
   logic [1:0] mem [4];
   logic [1:0] wp, rp;
   logic [2:0] count;
   logic wr;
   assign full = count == 3'd4;
   assign valid = count != 3'd0;
   // a pop frees the head slot in the same edge, so a push into a full FIFO still lands
   assign wr = push && (!full || pop);
   assign code = valid ? mem[rp] : 2'b00;
   always_ff @(posedge clock) if (wr) mem[wp] <= pcode;
   always_ff @(posedge clock) begin
      if (reset) begin
         wp <= '0;
         rp <= '0;
         count <= '0;
      end else begin
         if (wr) wp <= wp + 2'd1;
         if (pop) rp <= rp + 2'd1;
         count <= count + {2'b00, wr} - {2'b00, pop};
      end
   end
`else
   logic held;
   logic [1:0] hcode;
   assign full = held;
   assign valid = held;
   assign code = held ? hcode : 2'b00;
   always_ff @(posedge clock) begin
      if (reset) begin
         held <= 1'b0;
         hcode <= 2'b00;
      end else if (push && (!held || pop)) begin
         held <= 1'b1;
         hcode <= pcode;
      end else if (pop) held <= 1'b0;
   end
`endif
endmodule
